// File: rtl/stuff_or_data_mc_if.sv
// Beat, configuration and slot-flag signals of the multi-channel stuff/data slot generator.
// The master drives beats and config writes; the slave (the generator) returns per-beat flags.
interface stuff_or_data_mc_if #(
    parameter int MPT_W = 8,
    parameter int CH_N  = 4,
    parameter int CH_W  = (CH_N > 1) ? $clog2(CH_N) : 1
);
    logic             valid_in;
    logic             sof;
    logic [CH_W-1:0]  ch_id;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [MPT_W-1:0] cfg_pm;
    logic [MPT_W-1:0] cfg_cm;
    logic             valid_out;
    logic             sof_out;
    logic [CH_W-1:0]  ch_out;
    logic             ds;
    logic             eof_out;
    logic             err_sof_early;
    logic             err_sof_late;
    logic             input_err;

    modport master (
        output valid_in, sof, ch_id, cfg_we, cfg_ch, cfg_pm, cfg_cm,
        input  valid_out, sof_out, ch_out, ds, eof_out, err_sof_early, err_sof_late, input_err
    );

    modport slave (
        input  valid_in, sof, ch_id, cfg_we, cfg_ch, cfg_pm, cfg_cm,
        output valid_out, sof_out, ch_out, ds, eof_out, err_sof_early, err_sof_late, input_err
    );
endinterface

// File: rtl/stuff_or_data_mc.sv
// Multi-channel stuff/data slot generator: per channel, cm of every pm beats are flagged as
// data, spread evenly with a modulo accumulator; config is double-buffered and applied at sof.
module stuff_or_data_mc #(
    parameter int MPT_W = 8,
    parameter int CH_N  = 4,
    parameter int CH_W  = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    stuff_or_data_mc_if.slave bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    ch_state_t        r_state  [CH_N];
    logic [MPT_W-1:0] r_cnt    [CH_N];
    logic [MPT_W-1:0] r_acc    [CH_N];
    logic [MPT_W-1:0] r_sh_pm  [CH_N];
    logic [MPT_W-1:0] r_sh_cm  [CH_N];
    logic             r_sh_vld [CH_N];
    logic [MPT_W-1:0] r_act_pm [CH_N];
    logic [MPT_W-1:0] r_act_cm [CH_N];

    logic             w_ch_ok;
    logic             w_cfg_ok;
    ch_state_t        w_state_nxt;
    logic [MPT_W-1:0] w_cnt_nxt;
    logic [MPT_W-1:0] w_acc_nxt;
    logic [MPT_W-1:0] w_pm_nxt;
    logic [MPT_W-1:0] w_cm_nxt;
    logic [MPT_W:0]   w_sum;
    logic             w_upd;
    logic             w_ds;
    logic             w_eof;
    logic             w_early;
    logic             w_late;
    logic             w_beat_err;

    assign w_ch_ok  = int'(bus.ch_id) < CH_N;
    assign w_cfg_ok = (int'(bus.cfg_ch) < CH_N) && (bus.cfg_pm >= MPT_W'(2)) &&
                      (bus.cfg_cm != '0) && (bus.cfg_cm <= bus.cfg_pm);

    // Next state of the addressed channel; a sof restarts the accumulator from the shadow config.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nxt = r_state[bus.ch_id];
        w_cnt_nxt   = r_cnt[bus.ch_id];
        w_acc_nxt   = r_acc[bus.ch_id];
        w_pm_nxt    = r_act_pm[bus.ch_id];
        w_cm_nxt    = r_act_cm[bus.ch_id];
        w_sum       = '0;
        w_upd       = 1'b0;
        w_ds        = 1'b0;
        w_eof       = 1'b0;
        w_early     = 1'b0;
        w_late      = 1'b0;
        w_beat_err  = 1'b0;
        if (bus.valid_in) begin
            if (!w_ch_ok) begin
                w_beat_err = 1'b1;
            end else if (bus.sof) begin
                if (!r_sh_vld[bus.ch_id]) begin
                    w_beat_err = 1'b1;
                end else begin
                    w_upd       = 1'b1;
                    w_early     = (r_state[bus.ch_id] == ST_RUN);
                    w_pm_nxt    = r_sh_pm[bus.ch_id];
                    w_cm_nxt    = r_sh_cm[bus.ch_id];
                    w_sum       = {1'b0, r_sh_cm[bus.ch_id]};
                    w_cnt_nxt   = MPT_W'(1);
                    w_state_nxt = ST_RUN;
                end
            end else if (r_state[bus.ch_id] == ST_RUN) begin
                w_upd     = 1'b1;
                w_sum     = {1'b0, r_acc[bus.ch_id]} + {1'b0, r_act_cm[bus.ch_id]};
                w_cnt_nxt = r_cnt[bus.ch_id] + 1'b1;
            end else begin
                w_late = 1'b1;
            end

            if (w_upd) begin
                w_ds      = (w_sum >= {1'b0, w_pm_nxt});
                w_acc_nxt = w_ds ? MPT_W'(w_sum - {1'b0, w_pm_nxt}) : w_sum[MPT_W-1:0];
                if (w_cnt_nxt == w_pm_nxt) begin
                    w_eof       = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_acc_nxt   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-channel arrays are reset because every channel must start IDLE with
            // invalid config; they are small register files, not RAM.
            for (int i = 0; i < CH_N; i++) begin
                r_state[i]  <= ST_IDLE;
                r_cnt[i]    <= '0;
                r_acc[i]    <= '0;
                r_sh_pm[i]  <= '0;
                r_sh_cm[i]  <= '0;
                r_sh_vld[i] <= 1'b0;
                r_act_pm[i] <= '0;
                r_act_cm[i] <= '0;
            end
            bus.valid_out     <= 1'b0;
            bus.sof_out       <= 1'b0;
            bus.ch_out        <= '0;
            bus.ds            <= 1'b0;
            bus.eof_out       <= 1'b0;
            bus.err_sof_early <= 1'b0;
            bus.err_sof_late  <= 1'b0;
            bus.input_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates land together at the edge.
            bus.valid_out     <= bus.valid_in;
            bus.sof_out       <= bus.valid_in & bus.sof;
            bus.ch_out        <= bus.ch_id;
            bus.ds            <= w_ds;
            bus.eof_out       <= w_eof;
            bus.err_sof_early <= w_early;
            bus.err_sof_late  <= w_late;
            bus.input_err     <= w_beat_err | (bus.cfg_we & ~w_cfg_ok);

            if (bus.cfg_we && w_cfg_ok) begin
                r_sh_pm[bus.cfg_ch]  <= bus.cfg_pm;
                r_sh_cm[bus.cfg_ch]  <= bus.cfg_cm;
                r_sh_vld[bus.cfg_ch] <= 1'b1;
            end

            if (w_upd) begin
                r_state[bus.ch_id]  <= w_state_nxt;
                r_cnt[bus.ch_id]    <= w_cnt_nxt;
                r_acc[bus.ch_id]    <= w_acc_nxt;
                r_act_pm[bus.ch_id] <= w_pm_nxt;
                r_act_cm[bus.ch_id] <= w_cm_nxt;
            end
        end
    end
endmodule

// File: tb/tb_stuff_or_data_mc.sv
// Self-checking bench for stuff_or_data_mc: directed scenarios plus randomized multi-channel
// traffic, compared each cycle against a frame-index model (beat j is data iff (j*cm)%pm < cm).
module tb_stuff_or_data_mc;
    localparam int MPT_W = 8;
    localparam int CH_N  = 4;
    localparam int CH_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stuff_or_data_mc_if #(.MPT_W(MPT_W), .CH_N(CH_N), .CH_W(CH_W)) bus ();

    stuff_or_data_mc #(.MPT_W(MPT_W), .CH_N(CH_N), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state: shadow config, active config, beat index in frame, running flag.
    int m_sh_pm  [CH_N];
    int m_sh_cm  [CH_N];
    bit m_sh_vld [CH_N];
    int m_pm     [CH_N];
    int m_cm     [CH_N];
    int m_j      [CH_N];
    bit m_run    [CH_N];

    bit e_vout, e_sof, e_ds, e_eof, e_early, e_late, e_ierr;
    int e_ch;

    task automatic model(input bit r, input bit v, input bit s, input int ch,
                         input bit we, input int cch, input int pm, input int cm);
        bit cfg_ok;
        e_vout = 0; e_sof = 0; e_ds = 0; e_eof = 0; e_early = 0; e_late = 0; e_ierr = 0;
        e_ch = 0;
        if (r) begin
            for (int i = 0; i < CH_N; i++) begin
                m_sh_vld[i] = 0;
                m_run[i]    = 0;
                m_j[i]      = 0;
            end
            return;
        end
        cfg_ok = (cch < CH_N) && (pm >= 2) && (cm >= 1) && (cm <= pm);
        if (we && !cfg_ok) e_ierr = 1;
        e_vout = v;
        e_sof  = v && s;
        e_ch   = ch;
        if (v) begin
            if (ch >= CH_N) begin
                e_ierr = 1;
            end else if (s) begin
                if (!m_sh_vld[ch]) begin
                    e_ierr = 1;
                end else begin
                    e_early   = m_run[ch];
                    m_pm[ch]  = m_sh_pm[ch];
                    m_cm[ch]  = m_sh_cm[ch];
                    m_j[ch]   = 1;
                    e_ds      = ((m_cm[ch] % m_pm[ch]) < m_cm[ch]);
                    m_run[ch] = 1;
                end
            end else if (m_run[ch]) begin
                m_j[ch] = m_j[ch] + 1;
                e_ds    = (((m_j[ch] * m_cm[ch]) % m_pm[ch]) < m_cm[ch]);
                if (m_j[ch] == m_pm[ch]) begin
                    e_eof     = 1;
                    m_run[ch] = 0;
                end
            end else begin
                e_late = 1;
            end
        end
        if (we && cfg_ok) begin
            m_sh_pm[cch]  = pm;
            m_sh_cm[cch]  = cm;
            m_sh_vld[cch] = 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare every output after the edge.
    task automatic cyc(input bit r, input bit v, input bit s, input int ch,
                       input bit we, input int cch, input int pm, input int cm);
        rst          = r;
        bus.valid_in = v;
        bus.sof      = s;
        bus.ch_id    = CH_W'(ch);
        bus.cfg_we   = we;
        bus.cfg_ch   = CH_W'(cch);
        bus.cfg_pm   = MPT_W'(pm);
        bus.cfg_cm   = MPT_W'(cm);
        model(r, v, s, ch, we, cch, pm, cm);
        @(posedge clk);
        #1;
        check("valid_out",     bus.valid_out,     e_vout);
        check("sof_out",       bus.sof_out,       e_sof);
        check("ch_out",        bus.ch_out,        e_ch);
        check("ds",            bus.ds,            e_ds);
        check("eof_out",       bus.eof_out,       e_eof);
        check("err_sof_early", bus.err_sof_early, e_early);
        check("err_sof_late",  bus.err_sof_late,  e_late);
        check("input_err",     bus.input_err,     e_ierr);
    endtask

    task automatic beat(input int ch, input bit s);
        cyc(0, 1, s, ch, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int ch, input int pm, input int cm);
        cyc(0, 0, 0, 0, 1, ch, pm, cm);
    endtask

    task automatic rand_pm(output int pm);
        if ($urandom_range(0, 3) == 0) pm = $urandom_range(2, 255);
        else                           pm = $urandom_range(2, 24);
    endtask

    task automatic run_random();
        int frames_left [CH_N];
        int beats_left  [CH_N];
        int cycles;
        int total;
        int start;
        int ch;
        int c;
        int pm;
        int cm;
        bit v;
        bit s;
        bit we;
        for (int i = 0; i < CH_N; i++) begin
            frames_left[i] = 100;
            beats_left[i]  = 0;
            rand_pm(pm);
            cfg(i, pm, $urandom_range(1, pm));
        end
        cycles = 0;
        total  = 100 * CH_N;
        while (total > 0 && cycles < 90000) begin
            cycles++;
            start = $urandom_range(0, CH_N - 1);
            ch = -1;
            for (int k = 0; k < CH_N; k++) begin
                c = (start + k) % CH_N;
                if (ch < 0 && (frames_left[c] > 0 || beats_left[c] > 0)) ch = c;
            end
            v = ($urandom_range(0, 3) != 0);
            s = 0;
            if (v) begin
                if (beats_left[ch] == 0) begin
                    s = 1;
                    frames_left[ch]--;
                    beats_left[ch] = m_sh_pm[ch];
                end else if ($urandom_range(0, 99) == 0) begin
                    s = 1;
                    beats_left[ch] = m_sh_pm[ch];
                end
                beats_left[ch]--;
            end
            we = ($urandom_range(0, 7) == 0);
            rand_pm(pm);
            cm = $urandom_range(1, pm);
            if ($urandom_range(0, 15) == 0) begin
                if (pm < 255) cm = pm + 1;
                else          pm = 1;
            end
            cyc(0, v, s, ch, we, $urandom_range(0, CH_N - 1), pm, cm);
            total = 0;
            for (int k = 0; k < CH_N; k++) total += frames_left[k] + beats_left[k];
        end
        check("rand_work_left", total, 0);
    endtask

    logic [4:0] t1;
    logic [3:0] t2;
    logic [5:0] t3;
    logic [2:0] t3b;

    initial begin
        bus.valid_in = 0; bus.sof = 0; bus.ch_id = '0; bus.cfg_we = 0;
        bus.cfg_ch = '0; bus.cfg_pm = '0; bus.cfg_cm = '0;

        // Reset, including a beat and config write that reset must override.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0, 5, 3);

        // Single channel 5/3.
        cfg(0, 5, 3);
        for (int i = 0; i < 5; i++) begin
            beat(0, i == 0);
            t1[i] = bus.ds;
        end
        check("t1_ds_pattern", t1, 5'b11010);

        // ch0 5/3 and ch1 4/1 interleaved with random gaps.
        cfg(1, 4, 1);
        for (int k = 0; k < 9; k++) begin
            while ($urandom_range(0, 2) == 0) idle();
            beat(k % 2, k < 2);
            if (k % 2 == 1) t2[k / 2] = bus.ds;
        end
        check("t2_ch1_pattern", t2, 4'b1000);

        // Mid-frame config write does not disturb the running 8/5 frame.
        cfg(0, 8, 5);
        beat(0, 1);
        beat(0, 0);
        cfg(0, 3, 3);
        for (int i = 0; i < 6; i++) begin
            beat(0, 0);
            t3[i] = bus.ds;
        end
        check("t3_old_cfg", t3, 6'b110110);
        for (int i = 0; i < 3; i++) begin
            beat(0, i == 0);
            t3b[i] = bus.ds;
        end
        check("t3_new_cfg", t3b, 3'b111);

        // Early sof restarts the frame; beat after eof without sof is late.
        cfg(0, 6, 2);
        beat(0, 1);
        beat(0, 0);
        beat(0, 1);
        check("t4_early", bus.err_sof_early, 1);
        check("t4_restart_ds", bus.ds, 0);
        for (int i = 0; i < 5; i++) beat(0, 0);
        beat(0, 0);
        check("t4_late", bus.err_sof_late, 1);

        // Rejected config writes keep the 6/2 shadow; unconfigured channel is rejected.
        cfg(0, 4, 5);
        check("t5_bad_cm", bus.input_err, 1);
        cfg(0, 1, 1);
        check("t5_bad_pm", bus.input_err, 1);
        for (int i = 0; i < 6; i++) beat(0, i == 0);
        beat(2, 1);
        check("t5_unconf_err", bus.input_err, 1);
        beat(2, 0);

        // sof and config write on the same channel in the same cycle.
        cyc(0, 1, 1, 1, 1, 1, 7, 7);
        for (int i = 0; i < 3; i++) beat(1, 0);
        for (int i = 0; i < 7; i++) beat(1, i == 0);

        run_random();

        // Reset in the middle of a frame.
        cfg(0, 5, 3);
        beat(0, 1);
        beat(0, 0);
        cyc(1, 1, 0, 0, 1, 0, 5, 3);
        beat(0, 0);
        check("t7_late_after_rst", bus.err_sof_late, 1);
        beat(0, 1);
        check("t7_shadow_cleared", bus.input_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stuff_or_data_mc.md
# stuff_or_data_mc

Multi-channel, runtime-configurable successor to the single-channel stuff/data slot generator. It receives one time-multiplexed beat stream of up to CH_N channels and, for each accepted beat, flags the slot as data (ds=1) or stuff (ds=0). Within each frame of pm beats, exactly cm beats are data, spread evenly: beat j (1..pm) is data iff (j·cm) mod pm < cm. It sits between the packet framer and the payload mapper and keeps independent frame state and configuration per channel.

## Interface
- MPT_W, 8, width of pm/cm and of per-channel beat counter/accumulator
- CH_N, 4, number of channels (≥1)
- CH_W, $clog2(CH_N) (min 1), channel-id width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  beat valid
- sof  in  1  start of frame, qualified by valid_in
- ch_id  in  CH_W  channel of current beat
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_W  channel being configured
- cfg_pm  in  MPT_W  frame length in beats
- cfg_cm  in  MPT_W  data beats per frame
- valid_out  out  1  registered valid_in
- sof_out  out  1  registered sof & valid_in
- ch_out  out  CH_W  registered ch_id
- ds  out  1  1 = data slot, 0 = stuff slot
- eof_out  out  1  beat is last (pm-th) of its frame
- err_sof_early  out  1  pulse: sof arrived before the previous frame ended
- err_sof_late  out  1  pulse: beat without sof while channel expects sof
- input_err  out  1  pulse: rejected config write, or beat on unconfigured channel

## Operation
- Per channel: shadow {pm,cm}, active {pm,cm}, cnt (beats done in frame, 0..pm), acc (0..pm-1), state IDLE (expects sof) / RUN.
- Config write: accepted iff 2 ≤ cfg_pm and 1 ≤ cfg_cm ≤ cfg_pm; loads shadow of cfg_ch. Otherwise shadow unchanged, input_err=1 next cycle. cfg_ch ≥ CH_N: ignored, input_err=1.
- Shadow copied to active only on an accepted sof of that channel; a mid-frame write never disturbs the running frame. Write and sof on the same channel in the same cycle: sof uses the pre-write shadow.
- Beat accepted when valid_in=1; ch_id ≥ CH_N: no state change, valid_out=1, ds=0, input_err=1.
- sof beat: load active from shadow; if shadow invalid (never written since reset) → input_err=1, ds=0, channel stays IDLE. Else sum = 0 + cm, ds = (sum ≥ pm), acc = sum mod pm, cnt=1, state RUN (or IDLE if pm reached, impossible since pm≥2). If the channel was RUN with cnt<pm → also err_sof_early=1; frame restarts.
- Non-sof beat, RUN: sum = acc + cm (MPT_W+1 bits), ds = (sum ≥ pm), acc = ds ? sum−pm : sum, cnt+1; when cnt+1 = pm → eof_out=1, state IDLE, acc=0.
- Non-sof beat, IDLE: err_sof_late=1, ds=0, state unchanged.
- cm = pm: every beat ds=1. Errors are independent pulses; several may assert in the same cycle.

## Timing
- Latency 1 cycle: outputs for a beat at rising edge N are valid after edge N, for one cycle.
- valid_in=0: valid_out, sof_out, ds, eof_out, err_sof_early, err_sof_late all 0 next cycle; no channel state changes. input_err may still assert from a config write.
- Back-to-back beats on any channel mix, including the same channel on consecutive cycles, at full rate; state update must be visible to the next cycle's beat (no stale read).
- Reset: all outputs 0, ch_out=0; all channels IDLE, cnt=0, acc=0, shadow and active invalid. Reset mid-frame aborts all frames; the first beat after reset without sof → err_sof_late.
- Reset dominates cfg_we and valid_in in the same cycle.

## Test plan
- ch0 cfg pm=5,cm=3; 5 beats, sof on first → ds 0,1,0,1,1; eof_out on beat 5; no errors.
- ch0 pm=5,cm=3 and ch1 pm=4,cm=1 interleaved 0,1,0,1,…, random valid_in gaps → ch0 as above, ch1 ds 0,0,0,1; gap cycles give valid_out=0, ds=0.
- ch0 running pm=8,cm=5; cfg write pm=3,cm=3 after beat 2 → remaining 6 beats follow 8/5 pattern (beats 3..8: 0,1,1,0,1,1); next frame all ds=1.
- sof on ch0 at beat 3 of pm=6 frame → err_sof_early=1, ds of that beat as beat 1, frame restarts; beat after eof without sof → err_sof_late=1, ds=0.
- cfg pm=4,cm=5 and pm=1,cm=1 → input_err=1 each, shadow unchanged; sof on never-configured ch2 → input_err=1, ds=0.
- Random pm∈[2,2^MPT_W−1], cm∈[1,pm], 100 frames per channel with random valid → ds equals ((j·cm) mod pm < cm) for every j; rst asserted mid-frame → all outputs 0 next cycle.
